// File: rtl/spi_arb_4post.sv
// spi_arb_4post: two-requester round-robin arbiter in front of an SPI master.
// Ports: CLK/RST; Req0/1+Tx0/1 in; Done0/1, Err, Grant, Rx_out, Active out;
//        Go/Tx_word to master; Rx_word/Busy from master.
module spi_arb_4post #(
  parameter int unsigned TMO_CYC = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [15:0] Tx0,
  input  logic [15:0] Tx1,
  output logic        Done0,
  output logic        Done1,
  output logic        Err,
  output logic        Grant,
  output logic [15:0] Rx_out,
  output logic        Active,
  output logic        Go,
  output logic [15:0] Tx_word,
  input  logic [15:0] Rx_word,
  input  logic        Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_DONE,
    S_GAP,
    S_ABORT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t      state, state_n;
  logic [7:0]  tmo_cnt, tmo_n;
  logic [3:0]  gap_cnt, gap_n;
  logic        ptr, ptr_n;
  logic        grant_n;
  logic        win;
  logic [15:0] tx_n, rx_n;
  logic        done0_n, done1_n, err_n;
  logic        go_n, active_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
      gap_cnt <= '0;
      ptr     <= 1'b1;
      Grant   <= 1'b0;
      Tx_word <= '0;
      Rx_out  <= '0;
      Done0   <= 1'b0;
      Done1   <= 1'b0;
      Err     <= 1'b0;
      Go      <= 1'b0;
      Active  <= 1'b0;
    end else begin
      state   <= state_n;
      tmo_cnt <= tmo_n;
      gap_cnt <= gap_n;
      ptr     <= ptr_n;
      Grant   <= grant_n;
      Tx_word <= tx_n;
      Rx_out  <= rx_n;
      Done0   <= done0_n;
      Done1   <= done1_n;
      Err     <= err_n;
      Go      <= go_n;
      Active  <= active_n;
    end
  end

  always_comb begin
    state_n = state;
    tmo_n   = tmo_cnt;
    gap_n   = gap_cnt;
    ptr_n   = ptr;
    grant_n = Grant;
    tx_n    = Tx_word;
    rx_n    = Rx_out;
    done0_n = 1'b0;
    done1_n = 1'b0;
    err_n   = 1'b0;
    win     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!Busy && (Req0 || Req1)) begin
          // On a tie the requester not served last wins.
          if (Req0 && Req1) win = ~ptr;
          else              win = Req1;
          grant_n = win;
          tx_n    = win ? Tx1 : Tx0;
          tmo_n   = '0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (Busy) begin
          state_n = S_RUN;
        end else if (tmo_cnt == TMO_LAST) begin
          err_n   = 1'b1;
          state_n = S_ABORT;
        end else begin
          tmo_n = tmo_cnt + 8'd1;
        end
      end
      S_RUN: begin
        // Capture the receive word as Busy falls so Rx_out
        // is valid in the same cycle as the Done pulse.
        if (!Busy) begin
          rx_n    = Rx_word;
          done0_n = ~Grant;
          done1_n = Grant;
          state_n = S_DONE;
        end
      end
      S_DONE, S_ABORT: begin
        ptr_n   = Grant;
        gap_n   = '0;
        state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = S_IDLE;
        else                     gap_n = gap_cnt + 4'd1;
      end
      default: state_n = S_IDLE;
    endcase

    go_n     = (state_n == S_ISSUE);
    active_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_spi_arb_4post.sv
// tb_spi_arb_4post: scoreboard bench for spi_arb_4post.
// Stimulus pushes expected Go/Done/Err records; a negedge monitor checks them.
module tb_spi_arb_4post;

  localparam int TMO = 16;
  localparam int GAP = 2;

  logic        CLK, RST;
  logic        Req0, Req1;
  logic [15:0] Tx0, Tx1;
  logic        Done0, Done1, Err, Grant;
  logic [15:0] Rx_out;
  logic        Active, Go;
  logic [15:0] Tx_word;
  logic [15:0] Rx_word;
  logic        Busy;

  spi_arb_4post #(
    .TMO_CYC(TMO),
    .GAP_CYC(GAP)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Req0   (Req0),
    .Req1   (Req1),
    .Tx0    (Tx0),
    .Tx1    (Tx1),
    .Done0  (Done0),
    .Done1  (Done1),
    .Err    (Err),
    .Grant  (Grant),
    .Rx_out (Rx_out),
    .Active (Active),
    .Go     (Go),
    .Tx_word(Tx_word),
    .Rx_word(Rx_word),
    .Busy   (Busy)
  );

  typedef struct {
    logic [15:0] tx;
    int          len;
  } go_t;

  typedef struct {
    int          kind;
    logic        grant;
    logic [15:0] rx;
  } ev_t;

  go_t go_q[$];
  ev_t ev_q[$];

  int total = 0;
  int bad   = 0;
  bit m_en;
  int run_len;
  bit gap_chk_en;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_go(input logic [15:0] tx, input int len);
    go_t g;
    g.tx  = tx;
    g.len = len;
    go_q.push_back(g);
  endtask

  task automatic push_ev(input int kind, input logic gr,
                         input logic [15:0] rx);
    ev_t e;
    e.kind  = kind;
    e.grant = gr;
    e.rx    = rx;
    ev_q.push_back(e);
  endtask

  function automatic bit hit(input int which);
    case (which)
      0:       return Done0;
      1:       return Done1;
      2:       return Err;
      default: return Busy;
    endcase
  endfunction

  task automatic wait_ev(input int which, input int budget,
                         input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (hit(which)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_go"}, 32'(Go), 32'd0);
    chk({tag, "_active"}, 32'(Active), 32'd0);
    chk({tag, "_grant"}, 32'(Grant), 32'd0);
    chk({tag, "_tx"}, 32'(Tx_word), 32'd0);
    chk({tag, "_rx"}, 32'(Rx_out), 32'd0);
    chk({tag, "_done0"}, 32'(Done0), 32'd0);
    chk({tag, "_done1"}, 32'(Done1), 32'd0);
    chk({tag, "_err"}, 32'(Err), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // SPI master model: raises Busy inside the Go cycle, loops Tx_word
  // back into Rx_word when it finishes.
  initial begin
    Busy    = 1'b0;
    Rx_word = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (Go && m_en) begin
        Busy = 1'b1;
        repeat (run_len) @(posedge CLK);
        #1;
        Rx_word = Tx_word;
        Busy    = 1'b0;
      end
    end
  end

  // Monitor: pops and checks Go pulses and Done/Err events.
  initial begin
    logic        go_prev;
    logic        gtrack;
    logic [15:0] gtx;
    int          glen, gact, gidle;
    go_t         g;
    ev_t         e;
    go_prev = 1'b0;
    gtrack  = 1'b0;
    gtx     = '0;
    glen    = 0;
    gact    = 0;
    gidle   = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        go_prev = 1'b0;
        gtrack  = 1'b0;
      end else begin
        if (gtrack && !Go) begin
          if (Active) gact++;
          else        gidle++;
        end
        if (Done0 || Done1 || Err) begin
          chk("excl", 32'(Done0) + 32'(Done1) + 32'(Err), 32'd1);
          if (ev_q.size() == 0) begin
            chk("unexpected_ev", 32'd1, 32'd0);
          end else begin
            e = ev_q.pop_front();
            chk("ev_kind", Err ? 32'd2 : (Done1 ? 32'd1 : 32'd0),
                32'(e.kind));
            chk("ev_grant", 32'(Grant), 32'(e.grant));
            chk("ev_rx", 32'(Rx_out), 32'(e.rx));
          end
          gtrack = 1'b1;
          gact   = 0;
          gidle  = 0;
        end
        if (Go && !go_prev) begin
          gtx  = Tx_word;
          glen = 0;
          if (gtrack && gap_chk_en) begin
            chk("gap_cycles", 32'(gact), 32'(GAP));
            chk("gap_idle", 32'(gidle), 32'd1);
          end
          gtrack = 1'b0;
        end
        if (Go) glen++;
        if (!Go && go_prev) begin
          if (go_q.size() == 0) begin
            chk("unexpected_go", 32'd1, 32'd0);
          end else begin
            g = go_q.pop_front();
            chk("go_tx", 32'(gtx), 32'(g.tx));
            chk("go_len", 32'(glen), 32'(g.len));
          end
        end
        go_prev = Go;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    RST        = 1'b1;
    Req0       = 1'b0;
    Req1       = 1'b0;
    Tx0        = '0;
    Tx1        = '0;
    m_en       = 1'b1;
    run_len    = 4;
    gap_chk_en = 1'b0;

    @(negedge CLK);
    chk_reset("rst0");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Single request, loopback.
    push_go(16'hA5C3, 1);
    push_ev(0, 1'b0, 16'hA5C3);
    Tx0  = 16'hA5C3;
    Req0 = 1'b1;
    wait_ev(0, 60, "t_single");
    Req0 = 1'b0;
    repeat (6) @(negedge CLK);

    // Both requesting from reset: strict alternation.
    do_reset();
    gap_chk_en = 1'b1;
    run_len    = 3;
    Tx0        = 16'h1111;
    Tx1        = 16'h2222;
    for (int i = 0; i < 2; i++) begin
      push_go(16'h1111, 1);
      push_ev(0, 1'b0, 16'h1111);
      push_go(16'h2222, 1);
      push_ev(1, 1'b1, 16'h2222);
    end
    Req0 = 1'b1;
    Req1 = 1'b1;
    wait_ev(0, 60, "t_rr_a");
    wait_ev(1, 60, "t_rr_b");
    wait_ev(0, 60, "t_rr_c");
    wait_ev(1, 60, "t_rr_d");
    Req0 = 1'b0;
    Req1 = 1'b0;
    repeat (6) @(negedge CLK);

    // Master never busy: timeout, then retry succeeds.
    do_reset();
    m_en = 1'b0;
    push_go(16'hBEEF, TMO);
    push_ev(2, 1'b1, 16'h0000);
    Tx1  = 16'hBEEF;
    Req1 = 1'b1;
    wait_ev(2, 60, "t_tmo");
    m_en = 1'b1;
    push_go(16'hBEEF, 1);
    push_ev(1, 1'b1, 16'hBEEF);
    wait_ev(1, 60, "t_retry");
    Req1 = 1'b0;
    repeat (6) @(negedge CLK);

    // Reset in the middle of a transfer.
    gap_chk_en = 1'b0;
    run_len    = 10;
    push_go(16'h1234, 1);
    Tx1  = 16'h1234;
    Req1 = 1'b1;
    wait_ev(3, 40, "t_busy_up");
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk_reset("rst_mid");
    Req1 = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    push_go(16'h5555, 1);
    push_ev(0, 1'b0, 16'h5555);
    run_len = 4;
    Tx0  = 16'h5555;
    Req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!Busy) break;
      chk("blocked", 32'(Active), 32'd0);
    end
    wait_ev(0, 60, "t_after_rst");
    Req0 = 1'b0;
    repeat (6) @(negedge CLK);

    // Tx and Req changed while running.
    run_len = 6;
    push_go(16'hC0DE, 1);
    push_ev(0, 1'b0, 16'hC0DE);
    Tx0  = 16'hC0DE;
    Req0 = 1'b1;
    wait_ev(3, 40, "t_busy_run");
    Tx0  = 16'h0000;
    Req0 = 1'b0;
    @(negedge CLK);
    chk("tx_hold", 32'(Tx_word), 32'hC0DE);
    wait_ev(0, 40, "t_drop");
    repeat (10) @(negedge CLK);

    chk("go_q_empty", 32'(go_q.size()), 32'd0);
    chk("ev_q_empty", 32'(ev_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
